// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush scheduler for the 5-stage RV32I pipeline.
//
// It resolves three event sources and arbitrates between them with fixed
// priority (memory wait > taken branch > load-use):
//   - load-use hazard : one bubble into ID/EX while IF/ID and PC hold
//   - taken branch    : IF/ID and ID/EX flushed for FLUSH_CYCLES cycles
//   - data-mem wait   : whole front end frozen until memory is ready, plus
//                       one extra freeze cycle on the ready cycle
// All outputs are Mealy (combinational from state, cnt and inputs) so a
// hazard seen in cycle N is blocked in cycle N. While nRESET is low every
// output is forced to 0.
//
// Ports:
//   CLK, nRESET        clock (rising edge), asynchronous active-low reset
//   ifid_rs1_i/rs2_i   source register fields of the IF/ID instruction
//   idex_rd_i          destination register of the ID/EX instruction
//   idex_memread_i     ID/EX instruction is a load
//   branch_taken_i     branch/jump resolved taken this cycle
//   mem_ready_i        data memory can complete its access this cycle
//   pc_write_o         PC update enable
//   ifid_hazard_o      IF/ID hold
//   ifid_flush_o       IF/ID zero instruction
//   idex_flush_o       ID/EX bubble insert
//   state_o            current FSM state (debug)
//   stall_cnt_o        (PIPE_PERF_CNT_EN only) cycles with pc_write_o == 0
//   flush_cnt_o        (PIPE_PERF_CNT_EN only) cycles with ifid_flush_o == 1
//
// Optional feature macro: PIPE_PERF_CNT_EN adds the two wrapping 32-bit
// performance counters above.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 4
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic [REG_AW-1:0] ifid_rs1_i,
    input  logic [REG_AW-1:0] ifid_rs2_i,
    input  logic [REG_AW-1:0] idex_rd_i,
    input  logic              idex_memread_i,
    input  logic              branch_taken_i,
    input  logic              mem_ready_i,
    output logic              pc_write_o,
    output logic              ifid_hazard_o,
    output logic              ifid_flush_o,
    output logic              idex_flush_o,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o,
`endif
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MWAIT   = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    // Counter value loaded on the branch cycle: that cycle itself is the
    // first of the FLUSH_CYCLES flush cycles.
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic              w_load_use;
    logic              w_pc_write;
    logic              w_ifid_hazard;
    logic              w_ifid_flush;
    logic              w_idex_flush;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_load_use = idex_memread_i
                      & (idex_rd_i != {REG_AW{1'b0}})
                      & ((idex_rd_i == ifid_rs1_i) | (idex_rd_i == ifid_rs2_i));

    // State and flush counter register.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= RUN;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and Mealy output decode with fixed event priority.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pc_write    = 1'b1;
        w_ifid_hazard = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        case (r_state)
            RUN: begin
                if (!mem_ready_i) begin
                    w_pc_write    = 1'b0;
                    w_ifid_hazard = 1'b1;
                    w_state_nxt   = MWAIT;
                end else if (branch_taken_i) begin
                    // Branch beats load-use: the flush kills the dependent
                    // instruction, so no stall is needed.
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = FLUSH;
                        w_cnt_nxt   = FLUSH_RELOAD;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else if (w_load_use) begin
                    w_pc_write    = 1'b0;
                    w_ifid_hazard = 1'b1;
                    w_idex_flush  = 1'b1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            FLUSH: begin
                if (mem_ready_i) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    w_cnt_nxt    = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = FLUSH;
                    end
                end else begin
                    // Memory stall suspends the flush sequence; cnt holds.
                    w_pc_write    = 1'b0;
                    w_ifid_hazard = 1'b1;
                end
            end
            MWAIT: begin
                // The ready cycle is still frozen; RUN resumes after it.
                w_pc_write    = 1'b0;
                w_ifid_hazard = 1'b1;
                if (mem_ready_i) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = MWAIT;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign pc_write_o    = nRESET & w_pc_write;
    assign ifid_hazard_o = nRESET & w_ifid_hazard;
    assign ifid_flush_o  = nRESET & w_ifid_flush;
    assign idex_flush_o  = nRESET & w_idex_flush;
    assign state_o       = nRESET ? r_state : RUN;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Performance counters; both wrap naturally at 32 bits.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (!w_pc_write) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_ifid_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int FC = 3;

    logic          clk;
    logic          nreset;
    logic [AW-1:0] rs1, rs2, rd;
    logic          memread, br, ready;
    logic          pc_write, hz, fl, idf;
    logic [1:0]    st;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]   stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(FC), .CNT_W(4)) dut (
        .CLK            (clk),
        .nRESET         (nreset),
        .ifid_rs1_i     (rs1),
        .ifid_rs2_i     (rs2),
        .idex_rd_i      (rd),
        .idex_memread_i (memread),
        .branch_taken_i (br),
        .mem_ready_i    (ready),
        .pc_write_o     (pc_write),
        .ifid_hazard_o  (hz),
        .ifid_flush_o   (fl),
        .idex_flush_o   (idf),
`ifdef PIPE_PERF_CNT_EN
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt),
`endif
        .state_o        (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc;
        logic        hz;
        logic        fl;
        logic        idf;
        logic [1:0]  st;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: owed flush cycles and a "waiting for memory" flag.
    int          m_flush_left = 0;
    bit          m_wait       = 1'b0;
    logic [31:0] m_scnt       = 32'd0;
    logic [31:0] m_fcnt       = 32'd0;

    task automatic step(input logic r, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [AW-1:0] d, input logic mr, input logic b, input logic rdy);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        nreset = r; rs1 = a1; rs2 = a2; rd = d; memread = mr; br = b; ready = rdy;
        lu = mr && (d != 0) && (d == a1 || d == a2);
        e = '0;
        if (!r) begin
            m_flush_left = 0;
            m_wait       = 1'b0;
            m_scnt       = 32'd0;
            m_fcnt       = 32'd0;
        end else if (m_wait) begin
            e.st = 2'd2; e.hz = 1'b1;
            if (rdy) m_wait = 1'b0;
        end else if (m_flush_left > 0) begin
            e.st = 2'd1;
            if (rdy) begin
                e.pc = 1'b1; e.fl = 1'b1; e.idf = 1'b1;
                m_flush_left--;
            end else begin
                e.hz = 1'b1;
            end
        end else begin
            e.st = 2'd0;
            if (!rdy) begin
                e.hz = 1'b1; m_wait = 1'b1;
            end else if (b) begin
                e.pc = 1'b1; e.fl = 1'b1; e.idf = 1'b1;
                m_flush_left = FC - 1;
            end else if (lu) begin
                e.hz = 1'b1; e.idf = 1'b1;
            end else begin
                e.pc = 1'b1;
            end
        end
        e.scnt = m_scnt;
        e.fcnt = m_fcnt;
        q.push_back(e);
        if (r) begin
            if (!e.pc) m_scnt = m_scnt + 32'd1;
            if (e.fl)  m_fcnt = m_fcnt + 32'd1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: every cycle the DUT presents outputs mid-cycle; compare them.
    always @(negedge clk) begin
        exp_t e;
        logic [5:0] got, want;
        if (q.size() > 0) begin
            e    = q.pop_front();
            got  = {pc_write, hz, fl, idf, st};
            want = {e.pc, e.hz, e.fl, e.idf, e.st};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs t=%0t {pc,hz,fl,idf,st} got=%b want=%b", $time, got, want);
            end
            checks++;
            if (hz && fl) begin
                errors++;
                $display("FAIL hazard_flush_excl t=%0t hz=%b fl=%b want not both 1", $time, hz, fl);
            end
`ifdef PIPE_PERF_CNT_EN
            checks++;
            if (stall_cnt !== e.scnt || flush_cnt !== e.fcnt) begin
                errors++;
                $display("FAIL perf_cnt t=%0t stall=%0d/%0d flush=%0d/%0d (got/want)",
                         $time, stall_cnt, e.scnt, flush_cnt, e.fcnt);
            end
`endif
        end
    end

    initial begin
        nreset = 1'b0; rs1 = '0; rs2 = '0; rd = '0; memread = 1'b0; br = 1'b0; ready = 1'b1;
        // Held in reset with busy inputs: all outputs zero.
        step(1'b0, 5'd1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        // Load-use on rs2, then same with rd = x0.
        step(1'b1, 5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        idle(1);
        // Branch pulse: three flush cycles.
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        idle(4);
        // Memory wait of four cycles: five freeze cycles.
        for (int i = 0; i < 4; i++) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        // Branch + load-use together, then memory stall inside FLUSH.
        step(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(4);
        // Reset mid-FLUSH with branch high, then release.
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        idle(2);
        // Reset mid-MWAIT.
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 4) != 0));
        end
        idle(1);
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
